// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues word requests on the req/gnt/rvalid bus and queues
// the returned words in a small FIFO for the fetch stage. Redirects flush and drop stale data.
module instr_prefetch_buffer #(
    parameter logic [31:0] PC_RESET        = 32'h0,
    parameter int unsigned DEPTH           = 3,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_rvalid_i
);

    localparam int unsigned CntW = $clog2(DEPTH + 1) + 1;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW-1:0] DepthC   = CntW'(DEPTH);
    localparam logic [CntW-1:0] MaxOutC  = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
    localparam logic [31:0]     AlignMsk = 32'hFFFF_FFFC;
    localparam logic [31:0]     PcReset  = PC_RESET & AlignMsk;

    logic [31:0]     r_fetch_addr, r_rsp_addr, r_stale_addr;
    logic [CntW-1:0] r_outstanding, r_discard, r_cnt;
    logic [PtrW-1:0] r_wptr, r_rptr;
    logic            r_req_held, r_stale, r_err_stop;

    logic [31:0] r_mem_data [DEPTH];
    logic [31:0] r_mem_addr [DEPTH];
    logic        r_mem_err  [DEPTH];

    logic [31:0]     w_branch_addr;
    logic [CntW-1:0] w_out_next;
    logic            w_can_issue, w_gnt, w_rvalid, w_drop, w_push, w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign w_branch_addr = branch_addr_i & AlignMsk;
    assign w_can_issue   = req_i & ~r_err_stop & (r_outstanding < MaxOutC) &
                           ((r_cnt + r_outstanding) < DepthC);

    // Gated by rst so the bus request drops the instant reset asserts.
    assign instr_req_o  = ~rst & (r_req_held | w_can_issue);
    assign instr_addr_o = r_stale ? r_stale_addr : r_fetch_addr;
    assign busy_o       = (r_outstanding != '0) | instr_req_o;

    assign w_gnt      = instr_req_o & instr_gnt_i;
    assign w_rvalid   = instr_rvalid_i & (r_outstanding != '0);
    assign w_drop     = w_rvalid & (r_discard != '0);
    assign w_push     = w_rvalid & ~w_drop;
    assign w_pop      = valid_o & ready_i;
    assign w_out_next = r_outstanding + CntW'(w_gnt) - CntW'(w_rvalid);

    assign valid_o = (r_cnt != '0);
    assign rdata_o = r_mem_data[r_rptr];
    assign addr_o  = r_mem_addr[r_rptr];
    assign err_o   = valid_o & r_mem_err[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_addr  <= PcReset;
            r_rsp_addr    <= PcReset;
            r_stale_addr  <= PcReset;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_cnt         <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_req_held    <= 1'b0;
            r_stale       <= 1'b0;
            r_err_stop    <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            r_req_held    <= instr_req_o & ~instr_gnt_i;
            if (branch_i) begin
                // Everything in flight after this edge belongs to the old stream.
                r_fetch_addr <= w_branch_addr;
                r_rsp_addr   <= w_branch_addr;
                r_err_stop   <= 1'b0;
                r_discard    <= w_out_next;
                r_cnt        <= '0;
                r_wptr       <= '0;
                r_rptr       <= '0;
                r_stale      <= instr_req_o & ~instr_gnt_i;
                r_stale_addr <= instr_addr_o;
            end else begin
                if (w_gnt && !r_stale) r_fetch_addr <= r_fetch_addr + 32'd4;
                if (w_gnt) r_stale <= 1'b0;
                if (w_push) r_rsp_addr <= r_rsp_addr + 32'd4;
                if (w_push && instr_err_i) r_err_stop <= 1'b1;
                r_discard <= r_discard - CntW'(w_drop) + CntW'(w_gnt & r_stale);
                r_cnt     <= r_cnt + CntW'(w_push) - CntW'(w_pop);
                if (w_push) r_wptr <= ptr_inc(r_wptr);
                if (w_pop) r_rptr <= ptr_inc(r_rptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= instr_rdata_i;
            r_mem_addr[r_wptr] <= r_rsp_addr;
            r_mem_err[r_wptr]  <= instr_err_i;
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(instr_rvalid_i && r_outstanding == '0));
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= DepthC);
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        r_discard <= r_outstanding);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer: a bus model with in-order random-latency
// responses plus a stream-level scoreboard of expected addresses, data and request behaviour.
module tb_instr_prefetch_buffer;

    localparam logic [31:0] PcReset = 32'h100;
    localparam int Depth  = 3;
    localparam int MaxOut = 2;

    logic        clk, rst;
    logic        req_i, branch_i, ready_i, valid_o, err_o, busy_o;
    logic [31:0] branch_addr_i, rdata_o, addr_o, instr_addr_o, instr_rdata_i;
    logic        instr_req_o, instr_gnt_i, instr_err_i, instr_rvalid_i;

    instr_prefetch_buffer #(
        .PC_RESET        (PcReset),
        .DEPTH           (Depth),
        .MAX_OUTSTANDING (MaxOut)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .instr_rvalid_i (instr_rvalid_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int unsigned rdy;
        int unsigned epoch;
        bit          stale;
    } bus_t;

    bus_t q[$];

    int          n_checks, n_errors;
    int unsigned cyc, epoch;
    int          fifo_n, n_pops, pops_since_br, gnts_since_br;
    logic [31:0] exp_pop, exp_req_addr, err_addr, held_addr, first_pop, first_gnt, err_pop_addr;
    bit          held, stale_pend, err_stop, saw_err;
    bit          m_req, m_ready, br_now;
    int unsigned gnt_pct, lat_min, lat_max;
    logic [31:0] br_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check/settle at negedge+1, the following posedge commits.
    task automatic step();
        bit   exp_req, pop, gfire, rv;
        bus_t e;
        @(negedge clk);
        req_i         = m_req;
        branch_i      = br_now;
        branch_addr_i = br_tgt;
        ready_i       = br_now ? 1'b0 : m_ready;
        instr_gnt_i   = ($urandom_range(99) < gnt_pct);
        rv            = (q.size() != 0) && (q[0].rdy <= cyc);
        instr_rvalid_i = rv;
        if (rv) begin
            instr_rdata_i = mem_word(q[0].addr);
            instr_err_i   = (q[0].addr == err_addr);
        end else begin
            instr_rdata_i = $urandom;
            instr_err_i   = 1'($urandom_range(1));
        end
        #1;
        exp_req = held || (m_req && !err_stop && q.size() < MaxOut && fifo_n + q.size() < Depth);
        check("valid_o", 32'(valid_o), 32'(fifo_n != 0));
        check("instr_req_o", 32'(instr_req_o), 32'(exp_req));
        check("busy_o", 32'(busy_o), 32'(q.size() != 0 || exp_req));
        if (held) check("held_addr", instr_addr_o, held_addr);
        pop = (fifo_n != 0) && ready_i;
        if (pop) begin
            check("addr_o", addr_o, exp_pop);
            check("rdata_o", rdata_o, mem_word(exp_pop));
            check("err_o", 32'(err_o), 32'(exp_pop == err_addr));
            if (pops_since_br == 0) first_pop = addr_o;
            if (err_o && !saw_err) begin
                saw_err      = 1'b1;
                err_pop_addr = addr_o;
            end
            pops_since_br++;
            n_pops++;
            fifo_n--;
            exp_pop += 32'd4;
        end
        if (rv) begin
            e = q.pop_front();
            if (!e.stale && e.epoch == epoch) begin
                fifo_n++;
                if (e.addr == err_addr) err_stop = 1'b1;
            end
        end
        gfire = instr_req_o && instr_gnt_i;
        if (gfire) begin
            if (!stale_pend) begin
                check("gnt_addr", instr_addr_o, exp_req_addr);
                if (gnts_since_br == 0) first_gnt = instr_addr_o;
                gnts_since_br++;
                exp_req_addr += 32'd4;
            end
            e.addr  = instr_addr_o;
            e.rdy   = cyc + $urandom_range(lat_max, lat_min);
            e.epoch = epoch;
            e.stale = stale_pend;
            q.push_back(e);
            stale_pend = 1'b0;
        end
        check("max_outstanding", 32'(q.size() <= MaxOut), 32'd1);
        held      = instr_req_o && !instr_gnt_i;
        held_addr = instr_addr_o;
        if (br_now) begin
            epoch++;
            fifo_n        = 0;
            err_stop      = 1'b0;
            exp_pop       = br_tgt & 32'hFFFF_FFFC;
            exp_req_addr  = br_tgt & 32'hFFFF_FFFC;
            stale_pend    = held;
            pops_since_br = 0;
            gnts_since_br = 0;
        end
        cyc++;
    endtask

    task automatic branch_to(input logic [31:0] tgt);
        br_tgt = tgt;
        br_now = 1'b1;
        step();
        br_now = 1'b0;
    endtask

    // Asserts reset mid-cycle (no clock edge) and checks outputs drop at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst            = 1'b1;
        req_i          = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        branch_i       = 1'b0;
        ready_i        = 1'b1;
        #1;
        check("rst_instr_req", 32'(instr_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        q.delete();
        fifo_n        = 0;
        held          = 1'b0;
        stale_pend    = 1'b0;
        err_stop      = 1'b0;
        exp_pop       = PcReset;
        exp_req_addr  = PcReset;
        pops_since_br = 0;
        gnts_since_br = 0;
        epoch++;
        req_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p0, k;
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; ready_i = 1'b0;
        instr_gnt_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0; instr_rvalid_i = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; epoch = 0; n_pops = 0;
        err_addr = 32'h1; saw_err = 1'b0; br_now = 1'b0; br_tgt = '0;
        m_req = 1'b1; m_ready = 1'b1; gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();

        // Streaming: one word per cycle from PC_RESET.
        repeat (2) step();
        p0 = n_pops;
        repeat (20) step();
        check("stream_rate", 32'(n_pops - p0), 32'd20);
        check("stream_first", first_pop, PcReset);

        // Backpressure then release.
        m_ready = 1'b0;
        repeat (8) step();
        check("bp_req_stopped", 32'(instr_req_o), 32'd0);
        check("bp_valid", 32'(valid_o), 32'd1);
        m_ready = 1'b1;
        repeat (10) step();

        // Stale discard with two outstanding.
        lat_min = 3; lat_max = 3;
        k = 0;
        while (q.size() != 2 && k < 20) begin
            step();
            k++;
        end
        check("stale_setup", 32'(q.size()), 32'd2);
        branch_to(32'h200);
        lat_min = 1; lat_max = 1;
        repeat (10) step();
        check("stale_first_pop", first_pop, 32'h200);

        // Held request, then redirect while still un-granted.
        gnt_pct = 0;
        repeat (6) step();
        check("hold_req", 32'(instr_req_o), 32'd1);
        repeat (4) step();
        branch_to(32'h200);
        repeat (2) step();
        gnt_pct = 100;
        repeat (10) step();
        check("hold_first_gnt", first_gnt, 32'h200);
        check("hold_first_pop", first_pop, 32'h200);

        // Bus error stops fetching until a redirect.
        err_addr = 32'h108;
        saw_err  = 1'b0;
        do_reset();
        repeat (12) step();
        check("err_head_addr", err_pop_addr, 32'h108);
        check("err_req_stopped", 32'(instr_req_o), 32'd0);
        err_addr = 32'h1;
        branch_to(32'h0);
        repeat (8) step();
        check("err_restart", first_pop, 32'h0);

        // Address wrap.
        branch_to(32'hFFFF_FFF8);
        repeat (10) step();

        // Reset mid-operation.
        lat_min = 3; lat_max = 3; m_ready = 1'b0;
        repeat (4) step();
        do_reset();
        m_ready = 1'b1; lat_min = 1; lat_max = 1;
        repeat (6) step();
        check("post_rst_first", first_pop, PcReset);

        // Random traffic.
        gnt_pct = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            m_req   = ($urandom_range(99) < 90);
            m_ready = ($urandom_range(99) < 70);
            if (i == 700) begin
                do_reset();
            end else if ($urandom_range(99) < 3) begin
                k = int'($urandom_range(5));
                err_addr = $urandom_range(1) ? (br_tgt + 32'(4 * k)) : 32'h1;
                branch_to(($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h3FC));
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
